// File: rtl/addsub_arbiter.sv
// addsub_arbiter
//   Round-robin arbiter sharing one signed add/subtract datapath between
//   NUM_REQ requesters. At most one request is granted per cycle. The result
//   lands in a one-entry response register tagged with the requester index.
//   Response backpressure stalls all grants.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req_valid     per-requester operation valid
//   req_sub       per-requester op select (1 = A-B, 0 = A+B)
//   req_a/req_b   packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     one-hot (or zero) acceptance this cycle
//   rsp_valid     response register holds a result
//   rsp_ready     consumer takes the response this cycle
//   rsp_id        index of the requester that issued the operation
//   rsp_result    sum/difference modulo 2^DATA_WIDTH
//   rsp_overflow  signed overflow of the operation
//
// state | meaning
// IDLE  | response register empty
// FULL  | response register holds a result not yet taken
module addsub_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_sub,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_result,
  output logic                          rsp_overflow
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]            state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       win_id;
  logic [ID_W-1:0]       next_ptr;
  logic [NUM_REQ-1:0]    win;
  logic                  found;
  logic                  can_accept;
  logic                  handshake;
  logic                  sub_sel;
  logic                  ovf;
  logic [DATA_WIDTH-1:0] a_sel;
  logic [DATA_WIDTH-1:0] b_sel;
  logic [DATA_WIDTH-1:0] bx;
  logic [DATA_WIDTH-1:0] sum;

  // Scan k = 0..NUM_REQ-1 positions away from rr_ptr; the first valid
  // requester encountered wins.
  always_comb begin
    win    = '0;
    win_id = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (((int'(rr_ptr) + k) % NUM_REQ) == i)) begin
          found  = 1'b1;
          win[i] = 1'b1;
          win_id = ID_W'(i);
        end
      end
    end
  end

  // Operand mux driven by the one-hot win vector only, so operands never
  // reach req_ready or the response outputs combinationally.
  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    sub_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        a_sel   = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        b_sel   = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        sub_sel = req_sub[i];
      end
    end
  end

  // Subtraction as A + ~B + 1 so that B = -2^(W-1) needs no special case.
  assign bx  = sub_sel ? ~b_sel : b_sel;
  assign sum = a_sel + bx + DATA_WIDTH'(sub_sel);
  assign ovf = (a_sel[DATA_WIDTH-1] & bx[DATA_WIDTH-1] & ~sum[DATA_WIDTH-1]) |
               (~a_sel[DATA_WIDTH-1] & ~bx[DATA_WIDTH-1] & sum[DATA_WIDTH-1]);

  assign can_accept = (state == IDLE) | rsp_ready;
  assign req_ready  = win & {NUM_REQ{can_accept & rst_n}};
  assign handshake  = |(req_valid & req_ready);
  assign next_ptr   = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
  assign rsp_valid  = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
    end else if (handshake) begin
      // Also covers drain-and-accept in the same cycle: stays FULL.
      state        <= FULL;
      rr_ptr       <= next_ptr;
      rsp_id       <= win_id;
      rsp_result   <= sum;
      rsp_overflow <= ovf;
    end else if ((state == FULL) && rsp_ready) begin
      state <= IDLE;
    end
  end

endmodule
